// File: rtl/rom_dl_pkg.sv
// Shared types and constants for the ROM download router.
package rom_dl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        HOLD,
        DONE
    } dl_state_t;

    localparam int ROM_INDEX_DEFAULT = 0;
    localparam int CSUM_W            = 16;

endpackage

// File: rtl/dl_hold_timer.sv
// Loadable down-counter with a zero flag; times the post-download settle window.
module dl_hold_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             en,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (en && count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/rom_dl_router.sv
// Routes the hps_io ROM download into the core's load port, tracks size/checksum,
// and holds the core in reset until the download has settled.
module rom_dl_router
    import rom_dl_pkg::*;
#(
    parameter int DN_AW          = 18,
    parameter int ROM_BYTES      = 163840,
    parameter int EXPECTED_BYTES = 0,
    parameter int HOLD_CYCLES    = 16,
    parameter int ROM_INDEX      = ROM_INDEX_DEFAULT
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic [15:0]       ioctl_index,
    output logic [DN_AW-1:0]  dn_addr,
    output logic [7:0]        dn_data,
    output logic              dn_wr,
    output logic              core_reset,
    output logic              dl_done,
    output logic              dl_err_range,
    output logic              dl_err_size,
    output logic [17:0]       byte_count,
    output logic [CSUM_W-1:0] checksum
);

    localparam int          HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [24:0] ROM_LIMIT = 25'(ROM_BYTES);

    dl_state_t state, next_state;
    logic      start;
    logic      enter_load;
    logic      in_range;
    logic      hold_load;
    logic      hold_zero;

    assign start      = ioctl_download && (ioctl_index == 16'(ROM_INDEX));
    assign enter_load = start && (state != LOAD);
    assign in_range   = (ioctl_addr < ROM_LIMIT);
    assign hold_load  = (state == LOAD) && !ioctl_download;

    dl_hold_timer #(.WIDTH(HOLD_W)) u_hold_timer (
        .clk        (clk_sys),
        .rst_n      (reset_n),
        .load       (hold_load),
        .load_value (HOLD_W'(HOLD_CYCLES - 1)),
        .en         (state == HOLD),
        .zero       (hold_zero)
    );

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    // NOTE: defaulting next_state before the case keeps this block free of inferred latches.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = LOAD;
            LOAD:    if (!ioctl_download) next_state = HOLD;
            HOLD:    if (start) next_state = LOAD;
                     else if (hold_zero) next_state = DONE;
            DONE:    if (start) next_state = LOAD;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        core_reset = (state != DONE);
        dl_done    = (state == DONE);
    end

    // Writes are honoured for the whole LOAD state, including the cycle download drops.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dn_addr      <= '0;
            dn_data      <= '0;
            dn_wr        <= 1'b0;
            dl_err_range <= 1'b0;
            dl_err_size  <= 1'b0;
            byte_count   <= '0;
            checksum     <= '0;
        end else begin
            dn_wr <= 1'b0;
            if (enter_load) begin
                dl_err_range <= 1'b0;
                dl_err_size  <= 1'b0;
                byte_count   <= '0;
                checksum     <= '0;
            end else if (state == LOAD && ioctl_wr) begin
                if (in_range) begin
                    dn_addr  <= ioctl_addr[DN_AW-1:0];
                    dn_data  <= ioctl_dout;
                    dn_wr    <= 1'b1;
                    checksum <= checksum + {{(CSUM_W-8){1'b0}}, ioctl_dout};
                    if (byte_count != '1) byte_count <= byte_count + 18'd1;
                end else begin
                    dl_err_range <= 1'b1;
                end
            end
            if (state == HOLD && next_state == DONE) begin
                dl_err_size <= (EXPECTED_BYTES != 0) && (byte_count != 18'(EXPECTED_BYTES));
            end
        end
    end

endmodule

// File: tb/tb_rom_dl_router.sv
// Directed self-checking bench for rom_dl_router (EXPECTED_BYTES=4, HOLD_CYCLES=16).
module tb_rom_dl_router;

    localparam int H = 16;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b1;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic [15:0] ioctl_index = '0;
    logic [17:0] dn_addr;
    logic [7:0]  dn_data;
    logic        dn_wr;
    logic        core_reset;
    logic        dl_done;
    logic        dl_err_range;
    logic        dl_err_size;
    logic [17:0] byte_count;
    logic [15:0] checksum;

    int n_tests = 0;
    int n_fail  = 0;

    rom_dl_router #(
        .DN_AW(18), .ROM_BYTES(163840), .EXPECTED_BYTES(4), .HOLD_CYCLES(H), .ROM_INDEX(0)
    ) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ioctl_index(ioctl_index), .dn_addr(dn_addr), .dn_data(dn_data), .dn_wr(dn_wr),
        .core_reset(core_reset), .dl_done(dl_done), .dl_err_range(dl_err_range),
        .dl_err_size(dl_err_size), .byte_count(byte_count), .checksum(checksum)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic start_dl(input logic [15:0] idx);
        @(posedge clk_sys); #1;
        ioctl_download = 1'b1;
        ioctl_index    = idx;
    endtask

    // Pulses ioctl_wr for one cycle and returns the router outputs one cycle later.
    task automatic send_byte(input logic [24:0] a, input logic [7:0] d,
                             output logic wr_o, output logic [17:0] addr_o, output logic [7:0] data_o);
        @(posedge clk_sys); #1;
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_dout = d;
        @(posedge clk_sys); #1;
        ioctl_wr = 1'b0;
        wr_o   = dn_wr;
        addr_o = dn_addr;
        data_o = dn_data;
    endtask

    // Drops ioctl_download and waits (bounded) for dl_done.
    task automatic finish_dl(input string name);
        int waited;
        @(posedge clk_sys); #1;
        ioctl_download = 1'b0;
        waited = 0;
        while (!dl_done && waited < 60) begin
            @(posedge clk_sys); #1;
            waited++;
        end
        n_tests++;
        if (dl_done !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_done_timeout: dl_done=%b after %0d cycles, required 1", name, dl_done, waited);
        end
    endtask

    task automatic test_reset();
        #3 reset_n = 1'b0;
        #1;
        n_tests++;
        if ({core_reset, dn_wr, dl_done} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_async: core_reset/dn_wr/dl_done=%b required 100", {core_reset, dn_wr, dl_done});
        end
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys); reset_n = 1'b1;
        repeat (5) @(posedge clk_sys);
        #1;
        n_tests++;
        if ({core_reset, dn_wr, dl_done, dl_err_range, dl_err_size} !== 5'b10000 ||
            byte_count !== 18'd0 || checksum !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_hold: flags=%b count=%0d csum=%h required 10000/0/0000",
                     {core_reset, dn_wr, dl_done, dl_err_range, dl_err_size}, byte_count, checksum);
        end
    endtask

    task automatic test_basic_load();
        logic [7:0]  data_v [4] = '{8'h11, 8'h22, 8'h33, 8'hFF};
        logic        w;
        logic [17:0] a;
        logic [7:0]  d;
        int          fall_at;
        start_dl(16'd0);
        for (int i = 0; i < 4; i++) begin
            send_byte(25'(i), data_v[i], w, a, d);
            n_tests++;
            if (w !== 1'b1 || a !== 18'(i) || d !== data_v[i]) begin
                n_fail++;
                $display("FAIL basic_route%0d: wr=%b addr=%h data=%h required 1/%h/%h", i, w, a, d, 18'(i), data_v[i]);
            end
        end
        @(posedge clk_sys); #1;
        ioctl_download = 1'b0;
        @(posedge clk_sys); #1;
        fall_at = 0;
        for (int i = 1; i <= 40 && fall_at == 0; i++) begin
            @(posedge clk_sys); #1;
            if (!core_reset) fall_at = i;
        end
        n_tests++;
        if (fall_at != H) begin
            n_fail++;
            $display("FAIL basic_hold_len: core_reset fell after %0d cycles, required %0d", fall_at, H);
        end
        n_tests++;
        if (byte_count !== 18'd4 || checksum !== 16'h0165 || dl_done !== 1'b1 ||
            dl_err_range !== 1'b0 || dl_err_size !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_status: count=%0d csum=%h done=%b rng=%b size=%b required 4/0165/1/0/0",
                     byte_count, checksum, dl_done, dl_err_range, dl_err_size);
        end
    endtask

    task automatic test_async_reset_mid();
        @(negedge clk_sys); #2;
        reset_n = 1'b0;
        #1;
        n_tests++;
        if (core_reset !== 1'b1 || dl_done !== 1'b0 || byte_count !== 18'd0 || checksum !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_mid: core_reset=%b done=%b count=%0d csum=%h required 1/0/0/0000",
                     core_reset, dl_done, byte_count, checksum);
        end
        @(negedge clk_sys); reset_n = 1'b1;
    endtask

    task automatic test_range();
        logic        w;
        logic [17:0] a;
        logic [7:0]  d;
        start_dl(16'd0);
        send_byte(25'd0, 8'h5A, w, a, d);
        send_byte(25'd163840, 8'h77, w, a, d);
        n_tests++;
        if (w !== 1'b0 || dl_err_range !== 1'b1 || byte_count !== 18'd1) begin
            n_fail++;
            $display("FAIL range_drop: wr=%b rng=%b count=%0d required 0/1/1", w, dl_err_range, byte_count);
        end
        send_byte(25'd163839, 8'h01, w, a, d);
        n_tests++;
        if (w !== 1'b1 || a !== 18'd163839 || d !== 8'h01) begin
            n_fail++;
            $display("FAIL range_top: wr=%b addr=%0d data=%h required 1/163839/01", w, a, d);
        end
        finish_dl("range");
        n_tests++;
        if (dl_err_range !== 1'b1 || byte_count !== 18'd2 || checksum !== 16'h005B || dl_err_size !== 1'b1) begin
            n_fail++;
            $display("FAIL range_done: rng=%b count=%0d csum=%h size=%b required 1/2/005b/1",
                     dl_err_range, byte_count, checksum, dl_err_size);
        end
    endtask

    task automatic test_size();
        logic        w;
        logic [17:0] a;
        logic [7:0]  d;
        start_dl(16'd0);
        for (int i = 0; i < 3; i++) send_byte(25'(i + 16), 8'h01, w, a, d);
        finish_dl("size_short");
        n_tests++;
        if (dl_err_size !== 1'b1 || dl_err_range !== 1'b0 || byte_count !== 18'd3) begin
            n_fail++;
            $display("FAIL size_short: size=%b rng=%b count=%0d required 1/0/3", dl_err_size, dl_err_range, byte_count);
        end
        start_dl(16'd0);
        for (int i = 0; i < 4; i++) send_byte(25'(i), 8'h80, w, a, d);
        finish_dl("size_full");
        n_tests++;
        if (dl_err_size !== 1'b0 || byte_count !== 18'd4 || checksum !== 16'h0200) begin
            n_fail++;
            $display("FAIL size_full: size=%b count=%0d csum=%h required 0/4/0200", dl_err_size, byte_count, checksum);
        end
    endtask

    task automatic test_other_index();
        int wr_seen = 0;
        int rst_seen = 0;
        start_dl(16'd1);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk_sys); #1;
            if (dn_wr) wr_seen++;
            if (core_reset) rst_seen++;
            ioctl_wr   = (i % 2 == 0);
            ioctl_addr = 25'(i);
            ioctl_dout = 8'hA5;
        end
        @(posedge clk_sys); #1;
        ioctl_wr = 1'b0;
        ioctl_download = 1'b0;
        if (dn_wr) wr_seen++;
        n_tests++;
        if (wr_seen != 0 || rst_seen != 0 || dl_done !== 1'b1) begin
            n_fail++;
            $display("FAIL other_index_route: dn_wr pulses=%0d core_reset cycles=%0d done=%b required 0/0/1",
                     wr_seen, rst_seen, dl_done);
        end
        n_tests++;
        if (byte_count !== 18'd4 || checksum !== 16'h0200) begin
            n_fail++;
            $display("FAIL other_index_counts: count=%0d csum=%h required 4/0200", byte_count, checksum);
        end
        ioctl_index = 16'd0;
    endtask

    task automatic test_hold_restart();
        logic        w;
        logic [17:0] a;
        logic [7:0]  d;
        int          low_seen = 0;
        start_dl(16'd0);
        send_byte(25'd1, 8'h10, w, a, d);
        send_byte(25'd2, 8'h20, w, a, d);
        @(posedge clk_sys); #1;
        ioctl_download = 1'b0;
        @(posedge clk_sys); #1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_sys); #1;
            if (!core_reset) low_seen++;
        end
        ioctl_download = 1'b1;
        @(posedge clk_sys); #1;
        if (!core_reset) low_seen++;
        n_tests++;
        if (byte_count !== 18'd0 || checksum !== 16'd0) begin
            n_fail++;
            $display("FAIL restart_clear: count=%0d csum=%h required 0/0000", byte_count, checksum);
        end
        send_byte(25'd7, 8'h42, w, a, d);
        if (!core_reset) low_seen++;
        n_tests++;
        if (w !== 1'b1 || a !== 18'd7 || d !== 8'h42 || byte_count !== 18'd1) begin
            n_fail++;
            $display("FAIL restart_route: wr=%b addr=%0d data=%h count=%0d required 1/7/42/1", w, a, d, byte_count);
        end
        n_tests++;
        if (low_seen != 0) begin
            n_fail++;
            $display("FAIL restart_core_reset: core_reset low for %0d cycles, required 0", low_seen);
        end
        finish_dl("restart");
        n_tests++;
        if (checksum !== 16'h0042 || dl_err_size !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_done: csum=%h size=%b required 0042/1", checksum, dl_err_size);
        end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_async_reset_mid();
        test_range();
        test_size();
        test_other_index();
        test_hold_restart();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rom_dl_router.md
Name: rom_dl_router

Overview:
- Sits between the hps_io ioctl download stream and the williams2 core's dn_addr/dn_data/dn_wr ROM-load port, in the clk_sys (12 MHz) domain.
- Filters the stream by ioctl_index, registers and range-checks each byte, and counts bytes and keeps a running checksum.
- Holds the core in reset until the download ends plus a settle window, then reports done and error status for the OSD/LED.

Parameters:
- DN_AW, 18, width of dn_addr; the core ROM space is 2^DN_AW bytes.
- ROM_BYTES, 163840, highest legal address + 1; writes at or above it are dropped.
- EXPECTED_BYTES, 0, required total byte count; 0 disables the size check.
- HOLD_CYCLES, 16, clk_sys cycles that core_reset stays high after ioctl_download falls (must be ≥1).
- ROM_INDEX, 0, ioctl_index value routed to the core.

Ports:
- clk_sys  in  1  system clock (12 MHz).
- reset_n  in  1  asynchronous active-low reset.
- ioctl_download  in  1  download in progress.
- ioctl_wr  in  1  one-cycle byte strobe.
- ioctl_addr  in  25  byte address.
- ioctl_dout  in  8  byte data.
- ioctl_index  in  16  download slot.
- dn_addr  out  DN_AW  registered ROM address.
- dn_data  out  8  registered ROM data.
- dn_wr  out  1  registered one-cycle write strobe.
- core_reset  out  1  active-high reset request to the core, OR'd at top level with the other reset sources.
- dl_done  out  1  a complete download has finished.
- dl_err_range  out  1  sticky: at least one write was dropped.
- dl_err_size  out  1  sticky: byte count ≠ EXPECTED_BYTES.
- byte_count  out  18  accepted bytes in the current or last download.
- checksum  out  16  mod-2^16 sum of accepted bytes.

Behaviour:
- Reset (reset_n=0, async) values:
  - state = IDLE; all counters = 0.
  - dn_* = 0, dl_done = 0, both error flags = 0.
  - core_reset = 1 (core is held until a download completes).
- FSM states: IDLE, LOAD, HOLD, DONE.
- IDLE → LOAD on ioctl_download=1 with ioctl_index==ROM_INDEX.
  - On entry: clear byte_count, checksum, both error flags and dl_done; core_reset = 1.
  - A download with any other index is ignored in every state.
- LOAD, per cycle with ioctl_wr=1:
  - Accept if ioctl_addr < ROM_BYTES: next cycle dn_addr = ioctl_addr[DN_AW-1:0], dn_data = ioctl_dout, dn_wr = 1 (latency exactly 1 cycle); byte_count += 1; checksum += zero-extended ioctl_dout.
  - Reject otherwise: dn_wr = 0 and dl_err_range set; counters unchanged.
  - Cycles with ioctl_wr=0 give dn_wr = 0; dn_addr and dn_data hold their last values.
- LOAD → HOLD on ioctl_download falling.
  - A write strobe in that same cycle is still processed.
  - Load the hold counter with HOLD_CYCLES-1.
- HOLD: core_reset stays 1; the counter decrements each cycle. At 0, go to DONE.
- DONE:
  - core_reset = 0 and dl_done = 1.
  - dl_err_size = (EXPECTED_BYTES≠0) && (byte_count≠EXPECTED_BYTES), latched on entry.
- DONE → LOAD on a new matching download; this re-clears status and reasserts core_reset the same cycle.
- HOLD → LOAD if a matching download restarts during the hold; counters and flags are cleared.
- byte_count saturates at 2^18-1 and does not wrap. checksum wraps mod 2^16.
- ioctl_wr while ioctl_download=0, or while in IDLE/DONE, is ignored.
- dn_wr is never high for two consecutive cycles unless ioctl_wr was.

Decomposition:
- Shared package rom_dl_pkg holds:
  - typedef dl_state_t {IDLE, LOAD, HOLD, DONE};
  - constant ROM_INDEX_DEFAULT;
  - checksum width constant CSUM_W = 16.
- One natural sub-module: dl_hold_timer, a loadable down-counter with a zero flag used by the HOLD state.
- Everything else stays in rom_dl_router.

Test Plan:
1. Reset with reset_n low mid-cycle → core_reset=1, dn_wr=0, dl_done=0 immediately; these values hold after release with no download.
2. Index 0 download of 4 bytes at addrs 0..3, data 0x11,0x22,0x33,0xFF → four dn_wr pulses, each 1 cycle after its ioctl_wr, with matching addr/data. Then byte_count=4, checksum=0x0165, core_reset falls exactly HOLD_CYCLES cycles after ioctl_download falls, and dl_done=1.
3. Write to addr ROM_BYTES (163840) inside a download → no dn_wr, dl_err_range=1, byte_count unchanged; the flag persists into DONE.
4. EXPECTED_BYTES=4, download only 3 bytes → dl_err_size=1 at DONE. A second full 4-byte download clears it and reports 0.
5. ioctl_index=1 download with 10 writes → no dn_wr; state, core_reset and counters are unchanged.
6. Matching download restarts 5 cycles into HOLD → core_reset stays 1 continuously, byte_count resets to 0, and the new bytes are routed.
